// File: rtl/soc_sysid_checker_if.sv
// Avalon-MM read-only bus between the sysid checker and the interconnect.
// The checker drives the request side; the slave returns data and stalls.
interface soc_sysid_checker_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;
    logic              avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest,
        output avm_readdatavalid
    );
endinterface

// File: rtl/soc_sysid_checker.sv
// Boot-time system ID checker: reads sysid word 0 and word 1 over Avalon-MM,
// compares against expected constants and reports match/timeout status.
module soc_sysid_checker #(
    parameter int unsigned       ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter logic [31:0]       EXPECTED_ID    = 32'h0100_0001,
    parameter logic [31:0]       EXPECTED_TS    = 32'h5834_5328,
    parameter int unsigned       TIMEOUT_CYCLES = 255,
    parameter bit                AUTO_START     = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    soc_sysid_checker_if.master        avm,
    output logic                       busy,
    output logic                       done,
    output logic                       id_match,
    output logic                       ts_match,
    output logic                       timeout,
    output logic [31:0]                id_value,
    output logic [31:0]                ts_value
);

    typedef enum logic [2:0] {
        IDLE,
        ID_REQ,
        ID_WAIT,
        TS_REQ,
        TS_WAIT,
        FIN
    } state_t;

    localparam logic [15:0]       TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] TS_ADDR = BASE_ADDR + ADDR_W'(4);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        arm_q;
    logic        done_q, done_d;
    logic        idm_q, idm_d;
    logic        tsm_q, tsm_d;
    logic        to_q, to_d;
    logic [31:0] idv_q, idv_d;
    logic [31:0] tsv_q, tsv_d;

    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic              expired;

    // The phase budget is spent once this is its last allowed cycle.
    assign expired = (cnt_q >= TO_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            arm_q   <= AUTO_START;
            done_q  <= 1'b0;
            idm_q   <= 1'b0;
            tsm_q   <= 1'b0;
            to_q    <= 1'b0;
            idv_q   <= '0;
            tsv_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            arm_q   <= 1'b0;
            done_q  <= done_d;
            idm_q   <= idm_d;
            tsm_q   <= tsm_d;
            to_q    <= to_d;
            idv_q   <= idv_d;
            tsv_q   <= tsv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        done_d  = done_q;
        idm_d   = idm_q;
        tsm_d   = tsm_q;
        to_d    = to_q;
        idv_d   = idv_q;
        tsv_d   = tsv_q;
        rd      = 1'b0;
        addr    = '0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start || arm_q) begin
                    state_d = ID_REQ;
                    done_d  = 1'b0;
                    idm_d   = 1'b0;
                    tsm_d   = 1'b0;
                    to_d    = 1'b0;
                    idv_d   = '0;
                    tsv_d   = '0;
                end
            end
            ID_REQ: begin
                rd   = 1'b1;
                addr = BASE_ADDR;
                if (!avm.avm_waitrequest) begin
                    state_d = ID_WAIT;
                end else if (expired) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    to_d    = 1'b1;
                end
            end
            ID_WAIT: begin
                if (avm.avm_readdatavalid) begin
                    state_d = TS_REQ;
                    cnt_d   = '0;
                    idv_d   = avm.avm_readdata;
                    idm_d   = (avm.avm_readdata == EXPECTED_ID);
                end else if (expired) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    to_d    = 1'b1;
                end
            end
            TS_REQ: begin
                rd   = 1'b1;
                addr = TS_ADDR;
                if (!avm.avm_waitrequest) begin
                    state_d = TS_WAIT;
                end else if (expired) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    to_d    = 1'b1;
                end
            end
            TS_WAIT: begin
                if (avm.avm_readdatavalid) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    tsv_d   = avm.avm_readdata;
                    tsm_d   = (avm.avm_readdata == EXPECTED_TS);
                end else if (expired) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    to_d    = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign avm.avm_read    = rd;
    assign avm.avm_address = addr;
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign id_match        = idm_q;
    assign ts_match        = tsm_q;
    assign timeout         = to_q;
    assign id_value        = idv_q;
    assign ts_value        = tsv_q;

endmodule
